// File: rtl/wb_stage_mc_if.sv
// Bundle, memory-response and writeback signals of the writeback stage.
// The master side is the memory stage / data memory; the slave side is the stage itself.
interface wb_stage_mc_if #(
  parameter int REG_AW = 6,
  parameter int CNT_W  = 16
);
  logic              in_valid;
  logic              wb_allowin;
  logic              in_reg_en;
  logic [REG_AW-1:0] in_reg_waddr;
  logic              in_mem_read;
  logic [31:0]       in_alu_result;
  logic [2:0]        in_load_type;
  logic [31:0]       in_load_rt_data;
  logic              in_double_en;
  logic [63:0]       in_md_result;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;
  logic              flush;
  logic              wb_reg_we;
  logic [REG_AW-1:0] wb_reg_waddr;
  logic [31:0]       wb_reg_wdata;
  logic [31:0]       hi;
  logic [31:0]       lo;
  logic [CNT_W-1:0]  retire_cnt;
  logic              mem_err;

  modport master (
    output in_valid, in_reg_en, in_reg_waddr, in_mem_read, in_alu_result,
           in_load_type, in_load_rt_data, in_double_en, in_md_result,
           mem_rvalid, mem_rdata, flush,
    input  wb_allowin, wb_reg_we, wb_reg_waddr, wb_reg_wdata, hi, lo,
           retire_cnt, mem_err
  );

  modport slave (
    input  in_valid, in_reg_en, in_reg_waddr, in_mem_read, in_alu_result,
           in_load_type, in_load_rt_data, in_double_en, in_md_result,
           mem_rvalid, mem_rdata, flush,
    output wb_allowin, wb_reg_we, wb_reg_waddr, wb_reg_wdata, hi, lo,
           retire_cnt, mem_err
  );
endinterface

// File: rtl/wb_stage_mc.sv
// Registered writeback stage: holds one bundle, waits for load data when needed,
// formats loads, commits GPR and HI/LO writes and counts retired instructions.
module wb_stage_mc #(
  parameter int REG_AW = 6,
  parameter int CNT_W  = 16
) (
  input logic          clk,
  input logic          resetn,
  wb_stage_mc_if.slave bus
);
  typedef enum logic [1:0] {EMPTY, WAIT_MEM, COMMIT, DRAIN} state_t;

  typedef struct packed {
    logic              reg_en;
    logic [REG_AW-1:0] waddr;
    logic              mem_read;
    logic [31:0]       alu;
    logic [2:0]        ltype;
    logic [31:0]       rt;
    logic              double_en;
    logic [63:0]       md;
  } bundle_t;

  state_t           r_state;
  bundle_t          r_bundle;
  logic [31:0]      r_rdata;
  logic [31:0]      r_hi;
  logic [31:0]      r_lo;
  logic [CNT_W-1:0] r_cnt;
  logic             r_mem_err;

  bundle_t     w_in_bundle;
  logic        w_allowin;
  logic        w_accept;
  logic        w_commit;
  logic [1:0]  w_off;
  logic [7:0]  w_byte;
  logic [15:0] w_half;
  logic [31:0] w_load_data;

  assign w_in_bundle = '{reg_en:    bus.in_reg_en,
                         waddr:     bus.in_reg_waddr,
                         mem_read:  bus.in_mem_read,
                         alu:       bus.in_alu_result,
                         ltype:     bus.in_load_type,
                         rt:        bus.in_load_rt_data,
                         double_en: bus.in_double_en,
                         md:        bus.in_md_result};

  // flush blocks both the accept and the commit in the cycle it is raised
  assign w_allowin = (r_state == EMPTY || r_state == COMMIT) && !bus.flush;
  assign w_accept  = bus.in_valid && w_allowin;
  assign w_commit  = (r_state == COMMIT) && !bus.flush;
  assign w_off     = r_bundle.alu[1:0];
  assign w_byte    = r_rdata[{w_off, 3'b000} +: 8];

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_half      = 16'h0000;
    w_load_data = 32'h0000_0000;
    case (w_off)
      2'b00:   w_half = r_rdata[15:0];
      2'b10:   w_half = r_rdata[31:16];
      default: w_half = 16'h0000;
    endcase
    case (r_bundle.ltype)
      3'b000: w_load_data = r_rdata;
      3'b001: w_load_data = {{24{w_byte[7]}}, w_byte};
      3'b010: w_load_data = {24'h000000, w_byte};
      3'b011: w_load_data = {{16{w_half[15]}}, w_half};
      3'b100: w_load_data = {16'h0000, w_half};
      3'b101: begin
        case (w_off)
          2'b00:   w_load_data = {r_rdata[7:0],  r_bundle.rt[23:0]};
          2'b01:   w_load_data = {r_rdata[15:0], r_bundle.rt[15:0]};
          2'b10:   w_load_data = {r_rdata[23:0], r_bundle.rt[7:0]};
          default: w_load_data = r_rdata;
        endcase
      end
      3'b110: begin
        case (w_off)
          2'b00:   w_load_data = r_rdata;
          2'b01:   w_load_data = {r_bundle.rt[31:24], r_rdata[31:8]};
          2'b10:   w_load_data = {r_bundle.rt[31:16], r_rdata[31:16]};
          default: w_load_data = {r_bundle.rt[31:8],  r_rdata[31:24]};
        endcase
      end
      default: w_load_data = 32'h0000_0000;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state   <= EMPTY;
      r_bundle  <= '0;
      r_rdata   <= '0;
      r_hi      <= '0;
      r_lo      <= '0;
      r_cnt     <= '0;
      r_mem_err <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register reading pre-edge values.
      if (bus.mem_rvalid && (r_state == EMPTY || r_state == COMMIT)) r_mem_err <= 1'b1;
      if (w_commit) begin
        r_cnt <= r_cnt + 1'b1;
        if (r_bundle.double_en) begin
          r_hi <= r_bundle.md[63:32];
          r_lo <= r_bundle.md[31:0];
        end
      end
      if (w_accept) r_bundle <= w_in_bundle;
      case (r_state)
        EMPTY, COMMIT: begin
          if (w_accept) r_state <= w_in_bundle.mem_read ? WAIT_MEM : COMMIT;
          else          r_state <= EMPTY;
        end
        WAIT_MEM: begin
          if (bus.flush) begin
            r_state <= DRAIN;
          end else if (bus.mem_rvalid) begin
            r_rdata <= bus.mem_rdata;
            r_state <= COMMIT;
          end
        end
        DRAIN:   if (bus.mem_rvalid) r_state <= EMPTY;
        default: r_state <= EMPTY;
      endcase
    end
  end

  assign bus.wb_allowin   = w_allowin;
  assign bus.wb_reg_we    = w_commit && r_bundle.reg_en;
  assign bus.wb_reg_waddr = r_bundle.waddr;
  assign bus.wb_reg_wdata = r_bundle.mem_read ? w_load_data : r_bundle.alu;
  assign bus.hi           = r_hi;
  assign bus.lo           = r_lo;
  assign bus.retire_cnt   = r_cnt;
  assign bus.mem_err      = r_mem_err;
endmodule

// File: tb/tb_wb_stage_mc.sv
// Directed bench for wb_stage_mc: a commit scoreboard plus HI/LO/count/mem_err model
// checked every cycle, and literal expectations at the points the directed cases care about.
module tb_wb_stage_mc;
  logic clk;
  logic resetn;

  wb_stage_mc_if #(.REG_AW(6), .CNT_W(16)) bus ();

  wb_stage_mc #(.REG_AW(6), .CNT_W(16)) dut (
    .clk    (clk),
    .resetn (resetn),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        reg_en;
    logic [5:0]  waddr;
    logic [31:0] wdata;
    logic        double_en;
    logic [63:0] md;
  } exp_t;

  exp_t        q[$];
  logic [31:0] m_hi, m_lo;
  logic [15:0] m_cnt;
  logic        m_mem_err;
  logic        last_we;
  int unsigned n_checks, n_fail;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Load result from little-endian byte lanes, expressed with shifts and masks
  function automatic logic [31:0] model_load(input logic [2:0] t, input logic [1:0] off,
                                             input logic [31:0] d, input logic [31:0] rt);
    logic [31:0] b, h;
    int o;
    o = int'(off);
    b = (d >> (8 * o)) & 32'h0000_00FF;
    h = (o == 0) ? (d & 32'h0000_FFFF) : ((o == 2) ? (d >> 16) : 32'h0);
    case (t)
      3'd0:    return d;
      3'd1:    return b | (b[7] ? 32'hFFFF_FF00 : 32'h0);
      3'd2:    return b;
      3'd3:    return h | (h[15] ? 32'hFFFF_0000 : 32'h0);
      3'd4:    return h;
      3'd5:    return (d << (8 * (3 - o))) | (rt & (32'h00FF_FFFF >> (8 * o)));
      3'd6:    return (d >> (8 * o)) | (rt & ~(32'hFFFF_FFFF >> (8 * o)));
      default: return 32'h0;
    endcase
  endfunction

  task automatic drive_bundle(input logic reg_en, input logic [5:0] waddr, input logic mem_read,
                              input logic [31:0] alu, input logic [2:0] lt, input logic [31:0] rt,
                              input logic de, input logic [63:0] md);
    bus.in_valid        = 1'b1;
    bus.in_reg_en       = reg_en;
    bus.in_reg_waddr    = waddr;
    bus.in_mem_read     = mem_read;
    bus.in_alu_result   = alu;
    bus.in_load_type    = lt;
    bus.in_load_rt_data = rt;
    bus.in_double_en    = de;
    bus.in_md_result    = md;
  endtask

  task automatic drive_idle();
    bus.in_valid        = 1'b0;
    bus.in_reg_en       = 1'b0;
    bus.in_reg_waddr    = 6'd0;
    bus.in_mem_read     = 1'b0;
    bus.in_alu_result   = 32'h0;
    bus.in_load_type    = 3'd0;
    bus.in_load_rt_data = 32'h0;
    bus.in_double_en    = 1'b0;
    bus.in_md_result    = 64'h0;
  endtask

  task automatic push_exp(input logic reg_en, input logic [5:0] waddr, input logic [31:0] wdata,
                          input logic de, input logic [63:0] md);
    exp_t e;
    e.reg_en = reg_en; e.waddr = waddr; e.wdata = wdata; e.double_en = de; e.md = md;
    q.push_back(e);
  endtask

  // Load accepted at edge A, response sampled at edge A+lat, write seen in the following cycle
  task automatic do_load(input string name, input logic [2:0] lt, input logic [1:0] off,
                         input logic [31:0] rdata, input logic [31:0] rt, input int lat,
                         input logic [31:0] exp_lit);
    @(posedge clk); #1;
    drive_bundle(1'b1, 6'd9, 1'b1, {30'h0400_0000, off}, lt, rt, 1'b0, 64'h0);
    push_exp(1'b1, 6'd9, model_load(lt, off, rdata, rt), 1'b0, 64'h0);
    @(negedge clk);
    check({name, "_allowin_accept"}, bus.wb_allowin, 1'b1);
    for (int k = 1; k <= lat; k++) begin
      @(posedge clk); #1;
      drive_idle();
      bus.mem_rvalid = (k == lat);
      bus.mem_rdata  = rdata;
      @(negedge clk);
      check({name, "_allowin_wait"}, bus.wb_allowin, 1'b0);
    end
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check({name, "_we"}, bus.wb_reg_we, 1'b1);
    check({name, "_wdata"}, bus.wb_reg_wdata, exp_lit);
    @(posedge clk); #1;
  endtask

  // Scoreboard: a retire-count step pops one commit; a write strobe must match the head
  always @(negedge clk) begin
    exp_t e;
    if (resetn) begin
      if (bus.retire_cnt != m_cnt) begin
        if (q.size() == 0) begin
          check("commit_unexpected", bus.retire_cnt, m_cnt);
        end else begin
          check("retire_step", bus.retire_cnt, m_cnt + 16'd1);
          e = q.pop_front();
          check("commit_we_seen", last_we, e.reg_en);
          if (e.double_en) begin
            m_hi = e.md[63:32];
            m_lo = e.md[31:0];
          end
        end
        m_cnt = m_cnt + 16'd1;
      end
      check("hi", bus.hi, m_hi);
      check("lo", bus.lo, m_lo);
      check("mem_err", bus.mem_err, m_mem_err);
      if (bus.wb_reg_we) begin
        if (q.size() == 0) begin
          check("write_unexpected", bus.wb_reg_we, 1'b0);
        end else begin
          check("write_allowed", bus.wb_reg_we, q[0].reg_en);
          check("waddr", bus.wb_reg_waddr, q[0].waddr);
          check("wdata", bus.wb_reg_wdata, q[0].wdata);
        end
      end
      last_we = bus.wb_reg_we;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_checks = 0; n_fail = 0;
    m_hi = 32'h0; m_lo = 32'h0; m_cnt = 16'h0; m_mem_err = 1'b0; last_we = 1'b0;
    resetn = 1'b0;
    drive_idle();
    bus.mem_rvalid = 1'b0;
    bus.mem_rdata  = 32'h0;
    bus.flush      = 1'b0;
    repeat (2) @(posedge clk);
    #1 resetn = 1'b1;

    @(negedge clk);
    check("rst_allowin", bus.wb_allowin, 1'b1);
    check("rst_we", bus.wb_reg_we, 1'b0);
    check("rst_waddr", bus.wb_reg_waddr, 6'd0);
    check("rst_wdata", bus.wb_reg_wdata, 32'h0);
    check("rst_cnt", bus.retire_cnt, 16'd0);

    // Back-to-back ALU ops
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      drive_bundle(1'b1, 6'(i + 1), 1'b0, 32'h11 * (i + 1), 3'd0, 32'h0, 1'b0, 64'h0);
      push_exp(1'b1, 6'(i + 1), 32'h11 * (i + 1), 1'b0, 64'h0);
      @(negedge clk);
      check("b2b_allowin", bus.wb_allowin, 1'b1);
      if (i > 0) begin
        check("b2b_we", bus.wb_reg_we, 1'b1);
        check("b2b_wdata", bus.wb_reg_wdata, 32'h11 * i);
      end
    end
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("b2b_we_last", bus.wb_reg_we, 1'b1);
    check("b2b_wdata_last", bus.wb_reg_wdata, 32'h33);
    @(posedge clk); #1;
    @(negedge clk);
    check("b2b_we_off", bus.wb_reg_we, 1'b0);
    check("b2b_cnt", bus.retire_cnt, 16'd3);

    // Loads with varied latency and formatting
    do_load("lb",  3'd1, 2'd3, 32'h80FF_0000, 32'h0,         4, 32'hFFFF_FF80);
    do_load("lwl", 3'd5, 2'd1, 32'hAABB_CCDD, 32'h1122_3344, 1, 32'hCCDD_3344);
    do_load("lwr", 3'd6, 2'd2, 32'hAABB_CCDD, 32'h1122_3344, 2, 32'h1122_AABB);
    do_load("lh",  3'd3, 2'd2, 32'h8001_1234, 32'h0,         1, 32'hFFFF_8001);
    do_load("lbu", 3'd2, 2'd1, 32'h8001_1234, 32'h0,         1, 32'h0000_0012);
    do_load("lhu", 3'd4, 2'd1, 32'h8001_1234, 32'h0,         1, 32'h0000_0000);
    do_load("lw",  3'd0, 2'd0, 32'hCAFE_F00D, 32'h0,         3, 32'hCAFE_F00D);

    // Flush while waiting for memory: response is drained, nothing commits
    @(posedge clk); #1;
    drive_bundle(1'b1, 6'd4, 1'b1, 32'h0, 3'd0, 32'h0, 1'b0, 64'h0);
    @(posedge clk); #1;
    drive_idle();
    bus.flush = 1'b1;
    @(negedge clk);
    check("fl_allowin_flush", bus.wb_allowin, 1'b0);
    @(posedge clk); #1;
    bus.flush = 1'b0;
    @(negedge clk);
    check("fl_allowin_drain", bus.wb_allowin, 1'b0);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1;
    bus.mem_rdata  = 32'h1234_5678;
    @(negedge clk);
    check("fl_allowin_resp", bus.wb_allowin, 1'b0);
    check("fl_we_resp", bus.wb_reg_we, 1'b0);
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("fl_allowin_empty", bus.wb_allowin, 1'b1);
    check("fl_mem_err", bus.mem_err, 1'b0);

    // Flush during a commit cycle suppresses the write; flush in EMPTY blocks allowin
    @(posedge clk); #1;
    drive_bundle(1'b1, 6'd5, 1'b0, 32'h5555, 3'd0, 32'h0, 1'b0, 64'h0);
    @(posedge clk); #1;
    drive_idle();
    bus.flush = 1'b1;
    @(negedge clk);
    check("flc_we", bus.wb_reg_we, 1'b0);
    check("flc_allowin", bus.wb_allowin, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("fle_allowin", bus.wb_allowin, 1'b0);
    @(posedge clk); #1;
    bus.flush = 1'b0;

    // HI/LO write without a GPR write
    @(posedge clk); #1;
    drive_bundle(1'b0, 6'd6, 1'b0, 32'hDEAD_BEEF, 3'd0, 32'h0, 1'b1, 64'h0000_0001_FFFF_FFFE);
    push_exp(1'b0, 6'd6, 32'hDEAD_BEEF, 1'b1, 64'h0000_0001_FFFF_FFFE);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("md_we", bus.wb_reg_we, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("md_hi", bus.hi, 32'h0000_0001);
    check("md_lo", bus.lo, 32'hFFFF_FFFE);

    // Spurious response while EMPTY sets the sticky error
    @(posedge clk); #1;
    bus.mem_rvalid = 1'b1;
    @(posedge clk);
    m_mem_err = 1'b1;
    #1 bus.mem_rvalid = 1'b0;
    @(negedge clk);
    check("spur_mem_err", bus.mem_err, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("spur_mem_err_sticky", bus.mem_err, 1'b1);

    // Reset while a load is outstanding
    @(posedge clk); #1;
    drive_bundle(1'b1, 6'd8, 1'b1, 32'h0, 3'd0, 32'h0, 1'b0, 64'h0);
    @(posedge clk); #1;
    drive_idle();
    #2 resetn = 1'b0;
    m_hi = 32'h0; m_lo = 32'h0; m_cnt = 16'h0; m_mem_err = 1'b0; last_we = 1'b0;
    q.delete();
    #1;
    check("rr_allowin", bus.wb_allowin, 1'b1);
    check("rr_we", bus.wb_reg_we, 1'b0);
    check("rr_waddr", bus.wb_reg_waddr, 6'd0);
    check("rr_wdata", bus.wb_reg_wdata, 32'h0);
    check("rr_hi", bus.hi, 32'h0);
    check("rr_lo", bus.lo, 32'h0);
    check("rr_cnt", bus.retire_cnt, 16'd0);
    check("rr_mem_err", bus.mem_err, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;

    // Stage works normally again after the reset
    @(posedge clk); #1;
    drive_bundle(1'b1, 6'd7, 1'b0, 32'h77, 3'd0, 32'h0, 1'b0, 64'h0);
    push_exp(1'b1, 6'd7, 32'h77, 1'b0, 64'h0);
    @(posedge clk); #1;
    drive_idle();
    @(negedge clk);
    check("post_rst_we", bus.wb_reg_we, 1'b1);
    check("post_rst_wdata", bus.wb_reg_wdata, 32'h77);
    @(posedge clk); #1;
    @(negedge clk);
    check("post_rst_cnt", bus.retire_cnt, 16'd1);

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("queue_drained", 64'(q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
